// File: rtl/wb_pull_fifo.sv
// wb_pull_fifo: byte FIFO that fetches bytes from an upstream Wishbone source
// using classic read cycles and hands them out, one per read, to a downstream
// Wishbone controller.
// Optional feature macro: FIFO_STATUS_EN. When it is defined, a downstream read
// at address 1 returns the fill count instead of popping a byte.
module wb_pull_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       up_cyc_o,
  output logic       up_stb_o,
  output logic       up_we_o,
  input  logic [7:0] up_dat_i,
  input  logic       up_ack_i,
  input  logic       dn_cyc_i,
  input  logic       dn_stb_i,
  input  logic       dn_we_i,
  input  logic       dn_adr_i,
  output logic [7:0] dn_dat_o,
  output logic       dn_ack_o,
  output logic       dn_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {U_IDLE, U_FETCH} upState_t;
  typedef enum logic {D_IDLE, D_RESP} dnState_t;

  upState_t r_upState;
  dnState_t r_dnState;

  logic                  r_upCyc;
  logic                  r_dnAck;
  logic                  r_dnErr;
  logic [7:0]            r_dnDat;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [7:0]            r_buf [DEPTH];

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_dnReq;
  logic       w_readReq;
  logic       w_writeReq;
  logic       w_statusReq;
  logic [7:0] w_countByte;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A push happens only on the acknowledged beat of an outstanding fetch;
  // stray acks while idle are ignored.
  assign w_push = (r_upState == U_FETCH) && up_ack_i;

  // A new downstream request is only recognised while no response is showing,
  // so every ack/err stays a single-cycle pulse.
  assign w_dnReq    = dn_cyc_i && dn_stb_i && !r_dnAck && !r_dnErr &&
                      (r_dnState == D_IDLE);
  assign w_readReq  = w_dnReq && !dn_we_i;
  assign w_writeReq = w_dnReq && dn_we_i;

`ifdef FIFO_STATUS_EN
  assign w_statusReq = w_readReq && dn_adr_i;
`else
  logic w_unused_adr;
  assign w_unused_adr = dn_adr_i;
  assign w_statusReq  = 1'b0;
`endif

  // Pops are decided on the registered count, so a byte just pushed becomes
  // poppable one cycle later.
  assign w_pop = w_readReq && !w_statusReq && !w_empty;

  assign w_countByte = 8'(r_count);

  assign up_cyc_o = r_upCyc;
  assign up_stb_o = r_upCyc;
  assign up_we_o  = 1'b0;
  assign dn_dat_o = r_dnDat;
  assign dn_ack_o = r_dnAck;
  assign dn_err_o = r_dnErr;

  // Upstream fetch engine: start a read whenever there is room, drop it on ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_upState <= U_IDLE;
      r_upCyc   <= 1'b0;
      r_wrPtr   <= '0;
    end else begin
      case (r_upState)
        U_IDLE: begin
          if (!w_full) begin
            r_upCyc   <= 1'b1;
            r_upState <= U_FETCH;
          end
        end
        U_FETCH: begin
          if (up_ack_i) begin
            r_upCyc   <= 1'b0;
            r_wrPtr   <= r_wrPtr + PTR_ONE;
            r_upState <= U_IDLE;
          end
        end
        default: begin
          r_upCyc   <= 1'b0;
          r_upState <= U_IDLE;
        end
      endcase
    end
  end

  // Storage array: captures the fetched byte on the ack beat; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf[r_wrPtr] <= up_dat_i;
    end
  end

  // Downstream responder: ack a pop or status read, error a write, one pulse each.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dnState <= D_IDLE;
      r_dnAck   <= 1'b0;
      r_dnErr   <= 1'b0;
      r_dnDat   <= 8'h00;
      r_rdPtr   <= '0;
    end else begin
      case (r_dnState)
        D_IDLE: begin
          if (w_writeReq) begin
            r_dnErr   <= 1'b1;
            r_dnState <= D_RESP;
          end else if (w_statusReq) begin
            r_dnAck   <= 1'b1;
            r_dnDat   <= w_countByte;
            r_dnState <= D_RESP;
          end else if (w_pop) begin
            r_dnAck   <= 1'b1;
            r_dnDat   <= r_buf[r_rdPtr];
            r_rdPtr   <= r_rdPtr + PTR_ONE;
            r_dnState <= D_RESP;
          end
        end
        D_RESP: begin
          r_dnAck   <= 1'b0;
          r_dnErr   <= 1'b0;
          r_dnState <= D_IDLE;
        end
        default: begin
          r_dnAck   <= 1'b0;
          r_dnErr   <= 1'b0;
          r_dnState <= D_IDLE;
        end
      endcase
    end
  end

  // Fill level: simultaneous push and pop cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
